joy_conditioner: RTL and testbench
==================================

Name: joy_conditioner

Overview:
- Sits directly downstream of the serial joystick decoder and consumes its 16 active-low button lines (two players, 8 each).
- Debounces every line and resolves opposing directions (SOCD).
- Applies optional per-player autofire and an optional player swap.
- Presents registered, active-high Kempston-style bytes for the I/O port logic, plus a one-cycle change strobe.

Parameters:
DB_CYCLES, 1024, consecutive clk cycles a raw level must differ from the accepted level before it is accepted (>=2)
DB_W, 11, debounce counter width; must satisfy 2^DB_W > DB_CYCLES
AF_PERIOD, 1750000, clk cycles per autofire phase toggle (>=2)
AF_W, 21, autofire prescaler width; must satisfy 2^AF_W > AF_PERIOD

Ports:
clk  in  1  system clock, single domain, the decoder's clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
joy1_n  in  8  player 1 raw, active-low, order [7..0] = up,down,left,right,fire1,fire2,fire3,start
joy2_n  in  8  player 2 raw, same order
af_en  in  2  autofire enable; bit0 player 1, bit1 player 2
swap  in  1  1 = exchange players on the outputs
kemp1  out  8  port-1 byte, active-high: b0 right, b1 left, b2 down, b3 up, b4 fire1, b5 fire2, b6 fire3, b7 start
kemp2  out  8  port-2 byte, same layout
joy_state  out  16  debounced active-high state, {p2[7:0], p1[7:0]}, decoder order, pre-SOCD/autofire
changed  out  1  one-cycle pulse when any joy_state bit changed on the previous edge

Behaviour:
- Reset (rst_n=0 at a rising edge): all debounce counters=0, accepted levels=0 (released), prescaler=0, both autofire phases=1, kemp1=kemp2=0, joy_state=0, changed=0. Reset mid-debounce discards partial counts. Reset mid-autofire restarts the phase at 1.
- Raw inversion: r = ~joyN_n. Inputs are already synchronous to clk; no synchroniser stage.
- Debounce, per bit, independent:
  - If r == accepted: counter <= 0.
  - Else if counter == DB_CYCLES-1: accepted <= r, counter <= 0.
  - Else: counter++.
  - A glitch shorter than DB_CYCLES never reaches accepted. Any cycle with r == accepted restarts the count.
  - Latency: if r changes just before edge 0 and stays stable, accepted changes at edge DB_CYCLES-1.
- joy_state is the accepted vector itself.
- changed: registered; high for exactly one cycle, on the edge after any accepted bit toggles. Multiple bits toggling on the same edge still give one pulse.
- SOCD, per player, on the accepted state:
  - up&down both set: both forced 0.
  - left&right both set: both forced 0.
  - Fire and start bits are unaffected.
- Autofire:
  - Shared prescaler counts 0..AF_PERIOD-1 and wraps. tick = (prescaler == AF_PERIOD-1).
  - Per player: if accepted fire1 == 0, phase <= 1 (the first press fires immediately). Else if tick, phase <= ~phase.
  - Effective fire1 = accepted fire1 & (af_en[p] ? phase : 1).
  - fire2, fire3 and start are never autofired.
  - Changing af_en mid-press takes effect on the next output register update, with no glitch beyond one cycle.
- Output mapping: the SOCD/autofire result of player A goes to kemp1 and of player B to kemp2, where A=p1, B=p2 when swap=0, else reversed.
- kemp1/kemp2 are registered one stage after accepted/phase. Total input-to-kemp latency is DB_CYCLES cycles.
- The swap effect appears on the next edge.

Decomposition:
- Shared package joy_pkg:
  - Decoder-order bit indices JOY_UP=7, JOY_DOWN=6, JOY_LEFT=5, JOY_RIGHT=4, JOY_F1=3, JOY_F2=2, JOY_F3=1, JOY_START=0.
  - Kempston indices KEMP_RIGHT=0 … KEMP_START=7.
  - Function map_to_kemp(8-bit decoder-order vector) returning the Kempston-order byte.
- Sub-module joy_debounce_bit (parameters DB_CYCLES, DB_W; ports clk, rst_n, raw, level), instanced 16 times.
- SOCD, autofire and swap stay in the top module.

Test Plan (DB_CYCLES=4, AF_PERIOD=8 in simulation):
- Reset, then all inputs 8'hFF -> kemp1=kemp2=8'h00, joy_state=16'h0000, changed never pulses.
- joy1_n=8'hF7 (fire1) held -> joy_state[3]=1 at edge 3 after the change; changed=1 on the next cycle only; kemp1=8'h10 on the same edge; af_en=0.
- joy1_n pulses 8'h7F for 3 cycles then returns to FF -> joy_state stays 0 and kemp1 stays 00. The same pulse held 4 cycles -> kemp1=8'h08.
- joy2_n=8'h3F (up+down) -> kemp2 b2=b3=0. Then joy2_n=8'h7F -> kemp2=8'h08 after 4 cycles.
- af_en=2'b01, fire1 held -> kemp1[4]=1 initially, then toggles every 8 cycles (8 high, 8 low, …). Release and repress -> first sample is high again.
- swap=1 with p1 right (joy1_n=8'hEF) -> kemp2=8'h01, kemp1=8'h00. Assert rst_n=0 mid-debounce -> all outputs 0 on the next edge and the count restarts.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared joystick bit positions and the decoder-to-Kempston byte mapping.
package joy_pkg;

  localparam int unsigned JOY_W = 8;

  // Decoder order, [7..0]
  localparam int unsigned JOY_UP    = 7;
  localparam int unsigned JOY_DOWN  = 6;
  localparam int unsigned JOY_LEFT  = 5;
  localparam int unsigned JOY_RIGHT = 4;
  localparam int unsigned JOY_F1    = 3;
  localparam int unsigned JOY_F2    = 2;
  localparam int unsigned JOY_F3    = 1;
  localparam int unsigned JOY_START = 0;

  // Kempston port order
  localparam int unsigned KEMP_RIGHT = 0;
  localparam int unsigned KEMP_LEFT  = 1;
  localparam int unsigned KEMP_DOWN  = 2;
  localparam int unsigned KEMP_UP    = 3;
  localparam int unsigned KEMP_F1    = 4;
  localparam int unsigned KEMP_F2    = 5;
  localparam int unsigned KEMP_F3    = 6;
  localparam int unsigned KEMP_START = 7;

  function automatic logic [JOY_W-1:0] map_to_kemp(input logic [JOY_W-1:0] d);
    logic [JOY_W-1:0] k;
    k             = '0;
    k[KEMP_RIGHT] = d[JOY_RIGHT];
    k[KEMP_LEFT]  = d[JOY_LEFT];
    k[KEMP_DOWN]  = d[JOY_DOWN];
    k[KEMP_UP]    = d[JOY_UP];
    k[KEMP_F1]    = d[JOY_F1];
    k[KEMP_F2]    = d[JOY_F2];
    k[KEMP_F3]    = d[JOY_F3];
    k[KEMP_START] = d[JOY_START];
    return k;
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// Single-line debouncer: a new level is accepted only after DB_CYCLES
// consecutive cycles of disagreement with the current accepted level.
module joy_debounce_bit #(
  parameter int unsigned DB_CYCLES = 1024,
  parameter int unsigned DB_W      = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
      level <= raw;
      cnt   <= '0;
    end else begin
      cnt <= cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// Debounce, SOCD cleaning, autofire and player swap for two raw joysticks,
// producing registered active-high Kempston bytes and a change strobe.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1024,
  parameter int unsigned DB_W      = 11,
  parameter int unsigned AF_PERIOD = 1750000,
  parameter int unsigned AF_W      = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [JOY_W-1:0]  joy1_n,
  input  logic [JOY_W-1:0]  joy2_n,
  input  logic [1:0]        af_en,
  input  logic              swap,
  output logic [JOY_W-1:0]  kemp1,
  output logic [JOY_W-1:0]  kemp2,
  output logic [2*JOY_W-1:0] joy_state,
  output logic              changed
);

  localparam int unsigned N_BITS = 2 * JOY_W;

  logic [N_BITS-1:0] raw;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] acc_q;
  logic [AF_W-1:0]   presc;
  logic [1:0]        phase;
  logic              tick;
  logic [JOY_W-1:0]  eff1;
  logic [JOY_W-1:0]  eff2;

  assign raw = ~{joy2_n, joy1_n};

  for (genvar i = 0; i < N_BITS; i++) begin : g_db
    joy_debounce_bit #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .level(acc[i])
    );
  end

  assign joy_state = acc;
  assign tick      = (presc == AF_W'(AF_PERIOD - 1));

  // Opposing directions cancel; fire1 is gated by the autofire phase when enabled.
  function automatic logic [JOY_W-1:0] condition(input logic [JOY_W-1:0] s,
                                                 input logic af, input logic ph);
    logic [JOY_W-1:0] o;
    o = s;
    if (s[JOY_UP] && s[JOY_DOWN]) begin
      o[JOY_UP]   = 1'b0;
      o[JOY_DOWN] = 1'b0;
    end
    if (s[JOY_LEFT] && s[JOY_RIGHT]) begin
      o[JOY_LEFT]  = 1'b0;
      o[JOY_RIGHT] = 1'b0;
    end
    o[JOY_F1] = s[JOY_F1] & (af ? ph : 1'b1);
    return o;
  endfunction

  always_comb begin
    eff1 = condition(acc[JOY_W-1:0], af_en[0], phase[0]);
    eff2 = condition(acc[N_BITS-1:JOY_W], af_en[1], phase[1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      phase   <= 2'b11;
      acc_q   <= '0;
      changed <= 1'b0;
      kemp1   <= '0;
      kemp2   <= '0;
    end else begin
      presc <= tick ? '0 : presc + AF_W'(1);
      // Phase idles high so a fresh press fires on its first output cycle.
      phase[0] <= !acc[JOY_F1]         ? 1'b1 : (tick ? ~phase[0] : phase[0]);
      phase[1] <= !acc[JOY_W + JOY_F1] ? 1'b1 : (tick ? ~phase[1] : phase[1]);
      acc_q    <= acc;
      changed  <= |(acc ^ acc_q);
      kemp1    <= map_to_kemp(swap ? eff2 : eff1);
      kemp2    <= map_to_kemp(swap ? eff1 : eff2);
    end
  end

endmodule

// File: tb/tb_joy_conditioner.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs,
// an independent monitor compares them against the DUT each cycle.
module tb_joy_conditioner;

  localparam int unsigned DB_CYCLES = 4;
  localparam int unsigned DB_W      = 3;
  localparam int unsigned AF_PERIOD = 8;
  localparam int unsigned AF_W      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  joy1_n, joy2_n;
  logic [1:0]  af_en;
  logic        swap;
  logic [7:0]  kemp1, kemp2;
  logic [15:0] joy_state;
  logic        changed;

  always #5 clk = ~clk;

  joy_conditioner #(
    .DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .AF_PERIOD(AF_PERIOD), .AF_W(AF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .joy1_n(joy1_n), .joy2_n(joy2_n),
    .af_en(af_en), .swap(swap), .kemp1(kemp1), .kemp2(kemp2),
    .joy_state(joy_state), .changed(changed)
  );

  typedef struct packed {
    logic [7:0]  k1;
    logic [7:0]  k2;
    logic [15:0] js;
    logic        ch;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   armed  = 0;
  bit   done   = 0;

  // Reference state
  logic [15:0] m_acc, m_acc_prev;
  logic [15:0] m_hist[$];
  int          m_cyc;
  int          m_ticks[2];
  logic [7:0]  m_k1, m_k2;
  logic        m_ch;

  // Kempston bit k takes decoder bit k+4 for the directions, 7-k for buttons.
  function automatic logic [7:0] to_kemp(input logic [7:0] d);
    logic [7:0] k;
    for (int b = 0; b < 8; b++) k[b] = (b < 4) ? d[b + 4] : d[7 - b];
    return k;
  endfunction

  // Decoder order: 7 up, 6 down, 5 left, 4 right, 3 fire1.
  function automatic logic [7:0] player_out(input logic [7:0] s, input logic af, input int ticks);
    logic [7:0] o;
    o = s;
    if (s[7] && s[6]) o[7:6] = 2'b00;
    if (s[5] && s[4]) o[5:4] = 2'b00;
    if (af && (ticks % 2 == 1)) o[3] = 1'b0;
    return o;
  endfunction

  // Reference model: runs once per rising edge using the inputs present at that edge.
  initial forever begin
    logic [15:0] raw, nxt;
    logic [7:0]  pa, pb;
    bit          tick, all_diff;
    @(posedge clk);
    if (!rst_n) armed = 1;
    if (armed) begin
      if (!rst_n) begin
        m_acc = '0; m_acc_prev = '0; m_hist.delete(); m_cyc = 0;
        m_ticks[0] = 0; m_ticks[1] = 0; m_k1 = '0; m_k2 = '0; m_ch = 1'b0;
      end else begin
        raw  = ~{joy2_n, joy1_n};
        tick = (m_cyc % AF_PERIOD) == (AF_PERIOD - 1);
        pa   = player_out(m_acc[7:0],  af_en[0], m_ticks[0]);
        pb   = player_out(m_acc[15:8], af_en[1], m_ticks[1]);
        m_k1 = to_kemp(swap ? pb : pa);
        m_k2 = to_kemp(swap ? pa : pb);
        m_ch = (m_acc != m_acc_prev);
        for (int p = 0; p < 2; p++) begin
          if (!m_acc[8*p + 3]) m_ticks[p] = 0;
          else if (tick)       m_ticks[p] = m_ticks[p] + 1;
        end
        m_acc_prev = m_acc;
        m_hist.push_back(raw);
        if (m_hist.size() > DB_CYCLES) void'(m_hist.pop_front());
        nxt = m_acc;
        if (m_hist.size() == DB_CYCLES) begin
          for (int i = 0; i < 16; i++) begin
            all_diff = 1;
            foreach (m_hist[j]) if (m_hist[j][i] == m_acc[i]) all_diff = 0;
            if (all_diff) nxt[i] = ~m_acc[i];
          end
        end
        m_acc = nxt;
        m_cyc++;
      end
      exp_q.push_back('{k1: m_k1, k2: m_k2, js: m_acc, ch: m_ch});
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: samples DUT outputs after each edge and retires one expectation.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("kemp1",     {8'h00, kemp1}, {8'h00, e.k1});
      check("kemp2",     {8'h00, kemp2}, {8'h00, e.k2});
      check("joy_state", joy_state,      e.js);
      check("changed",   {15'h0, changed}, {15'h0, e.ch});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] h1, h2;
    rst_n = 1'b0; joy1_n = 8'hFF; joy2_n = 8'hFF; af_en = 2'b00; swap = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    // Single fire1 press and release
    joy1_n = 8'hF7; step(12);
    joy1_n = 8'hFF; step(8);
    // Glitch one cycle short of acceptance, then exactly long enough
    joy1_n = 8'h7F; step(3);
    joy1_n = 8'hFF; step(8);
    joy1_n = 8'h7F; step(4);
    joy1_n = 8'hFF; step(8);
    // Up+down cancel, then up alone
    joy2_n = 8'h3F; step(8);
    joy2_n = 8'h7F; step(8);
    joy2_n = 8'hFF; step(8);
    // Autofire on player 1, release and repress
    af_en = 2'b01;
    joy1_n = 8'hF7; step(40);
    joy1_n = 8'hFF; step(6);
    joy1_n = 8'hF7; step(20);
    af_en = 2'b00; step(4);
    joy1_n = 8'hFF; step(8);
    // Swap with p1 right, then reset mid-debounce
    swap = 1'b1;
    joy1_n = 8'hEF; step(8);
    joy1_n = 8'hFF; step(2);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; step(10);
    swap = 1'b0;
    // Randomized walk: single-bit flips held for varying lengths
    h1 = 8'hFF; h2 = 8'hFF;
    repeat (400) begin
      if ($urandom_range(0, 1) == 1) h1 = h1 ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) h2 = h2 ^ (8'h01 << $urandom_range(0, 7));
      joy1_n = h1; joy2_n = h2;
      if ($urandom_range(0, 9) == 0) af_en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) swap = ~swap;
      rst_n = ($urandom_range(0, 59) != 0);
      step(int'($urandom_range(1, 12)));
      rst_n = 1'b1;
    end
    step(4);
    done = 1;
    if (checks == 0) begin
      errors++;
      $display("FAIL no_checks: got 0 comparisons expected >0");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
